// File: rtl/stream_arb2.sv
`timescale 1ns/1ps
// stream_arb2
// Two-source valid/ready stream arbiter with per-packet round-robin priority
// and a one-entry registered output stage. A source that wins keeps the
// grant until its LAST beat is accepted. The output carries the selected
// beat plus the select value s that picked it.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_valid, a_data, a_last       source A beat
//   a_ready                       source A beat accepted this cycle
//   b_valid, b_data, b_last       source B beat
//   b_ready                       source B beat accepted this cycle
//   z_valid, z_data, z_last, s    registered output beat and its source (0=A, 1=B)
//   z_ready                       downstream accepts output beat
//
// state  | meaning
// IDLE   | no packet in progress, arbitrate on valid and pri
// LOCK_A | packet from A in progress, only A may be granted
// LOCK_B | packet from B in progress, only B may be granted

module stream_arb2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_data,
    output logic             z_last,
    output logic             s,
    input  logic             z_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   pri, pri_nxt;        // 0 = A has priority, 1 = B
    logic   load;
    logic   grant_a, grant_b;
    logic   acc_a, acc_b;

    // Output register can take a new beat when empty or draining this edge.
    assign load = !z_valid || z_ready;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a = !pri;
                    grant_b = pri;
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
            LOCK_A:  grant_a = 1'b1;
            LOCK_B:  grant_b = 1'b1;
            default: ;
        endcase
    end

    // rst_n gates ready so nothing is offered while the block is held in reset.
    assign a_ready = rst_n && load && grant_a;
    assign b_ready = rst_n && load && grant_b;
    assign acc_a   = a_valid && a_ready;
    assign acc_b   = b_valid && b_ready;

    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        if (acc_a) begin
            if (a_last) begin
                state_nxt = IDLE;
                pri_nxt   = 1'b1;
            end else begin
                state_nxt = LOCK_A;
            end
        end else if (acc_b) begin
            if (b_last) begin
                state_nxt = IDLE;
                pri_nxt   = 1'b0;
            end else begin
                state_nxt = LOCK_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pri   <= 1'b0;
        end else begin
            state <= state_nxt;
            pri   <= pri_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_valid <= 1'b0;
            z_data  <= '0;
            z_last  <= 1'b0;
            s       <= 1'b0;
        end else if (acc_a) begin
            z_valid <= 1'b1;
            z_data  <= a_data;
            z_last  <= a_last;
            s       <= 1'b0;
        end else if (acc_b) begin
            z_valid <= 1'b1;
            z_data  <= b_data;
            z_last  <= b_last;
            s       <= 1'b1;
        end else if (z_ready) begin
            z_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb2.sv
`timescale 1ns/1ps
module tb_stream_arb2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       z_valid, z_last, s, z_ready;
    logic [7:0] z_data;

    int checks = 0;
    int errors = 0;

    stream_arb2 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .z_valid(z_valid), .z_data(z_data), .z_last(z_last), .s(s),
        .z_ready(z_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: -1 no packet open, 0 packet from A open, 1 packet from B open.
    int         m_own = -1;
    bit         m_pri = 1'b0;
    bit         m_zv = 1'b0;
    logic [7:0] m_zd = 8'h00;
    bit         m_zl = 1'b0;
    bit         m_zs = 1'b0;
    bit         m_acc_a = 1'b0;
    bit         m_acc_b = 1'b0;

    function automatic int m_grant();
        if (m_own >= 0)            return m_own;
        if (a_valid && b_valid)    return int'(m_pri);
        if (a_valid)               return 0;
        if (b_valid)               return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int src);
        return rst_n && (!m_zv || z_ready) && (m_grant() == src);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own   <= -1;
            m_pri   <= 1'b0;
            m_zv    <= 1'b0;
            m_zd    <= 8'h00;
            m_zl    <= 1'b0;
            m_zs    <= 1'b0;
            m_acc_a <= 1'b0;
            m_acc_b <= 1'b0;
        end else begin
            bit ta, tb;
            ta = m_ready(0) && a_valid;
            tb = m_ready(1) && b_valid;
            m_acc_a <= ta;
            m_acc_b <= tb;
            if (ta || tb) begin
                m_zv <= 1'b1;
                m_zd <= ta ? a_data : b_data;
                m_zl <= ta ? a_last : b_last;
                m_zs <= tb;
                if (ta ? a_last : b_last) begin
                    m_own <= -1;
                    m_pri <= ta;     // priority passes to the other source
                end else begin
                    m_own <= ta ? 0 : 1;
                end
            end else if (z_ready) begin
                m_zv <= 1'b0;
            end
        end
    end

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_a_ready", a_ready, m_ready(0));
        check("model_b_ready", b_ready, m_ready(1));
        check("model_z_valid", z_valid, m_zv);
        if (m_zv) begin
            check("model_z_data", z_data, m_zd);
            check("model_z_last", z_last, m_zl);
            check("model_s", s, m_zs);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic l);
        a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] d, input logic l);
        b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic check_z(input string name, input logic v, input logic [7:0] d,
                           input logic l, input logic src);
        check({name, "_z_valid"}, z_valid, v);
        check({name, "_z_data"}, z_data, d);
        check({name, "_z_last"}, z_last, l);
        check({name, "_s"}, s, src);
    endtask

    task automatic reset_dut();
        drive_a(0, 8'h00, 0);
        drive_b(0, 8'h00, 0);
        z_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_z_valid", z_valid, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na, nb, a_rem, b_rem;
        rst_n = 1'b1;
        #1;
        reset_dut();

        // A only, three-beat packet
        drive_a(1, 8'h11, 0);
        #1 check("t1_a_ready", a_ready, 1);
        cyc(); check_z("t1_b0", 1, 8'h11, 0, 0);
        drive_a(1, 8'h22, 0);
        cyc(); check_z("t1_b1", 1, 8'h22, 0, 0);
        drive_a(1, 8'h33, 1);
        cyc(); check_z("t1_b2", 1, 8'h33, 1, 0);
        drive_a(0, 8'h00, 0);
        cyc(); check("t1_drain", z_valid, 0);

        // Contention with single-beat packets: A first, then alternate
        reset_dut();
        na = 0; nb = 0;
        drive_a(1, 8'hA0, 1);
        drive_b(1, 8'hB0, 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_a_ready", a_ready, (i % 2) == 0);
            check("t2_b_ready", b_ready, (i % 2) == 1);
            cyc();
            if (i % 2 == 0) begin
                check_z("t2_a", 1, 8'hA0 + 8'(na), 1, 0);
                na++;
                a_data = 8'hA0 + 8'(na);
            end else begin
                check_z("t2_b", 1, 8'hB0 + 8'(nb), 1, 1);
                nb++;
                b_data = 8'hB0 + 8'(nb);
            end
        end
        drive_a(0, 8'h00, 0);
        drive_b(0, 8'h00, 0);

        // Packet lock: B waits for A's last beat, then follows without a bubble
        reset_dut();
        drive_b(1, 8'hC1, 1);
        for (int j = 0; j < 3; j++) begin
            drive_a(1, 8'h31 + 8'(j), j == 2);
            #1;
            check("t3_b_ready_locked", b_ready, 0);
            check("t3_a_ready", a_ready, 1);
            cyc();
            check_z("t3_a", 1, 8'h31 + 8'(j), j == 2, 0);
        end
        drive_a(0, 8'h00, 0);
        #1 check("t3_b_ready_free", b_ready, 1);
        cyc(); check_z("t3_b", 1, 8'hC1, 1, 1);
        drive_b(0, 8'h00, 0);

        // Backpressure holding 0x5A, then drain and reload on the same edge
        drive_a(1, 8'h5A, 1);
        cyc(); check_z("t4_load", 1, 8'h5A, 1, 0);
        z_ready = 1'b0;
        drive_a(1, 8'h6B, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_a_ready_stall", a_ready, 0);
            check("t4_b_ready_stall", b_ready, 0);
            cyc();
            check_z("t4_hold", 1, 8'h5A, 1, 0);
        end
        z_ready = 1'b1;
        #1 check("t4_a_ready_release", a_ready, 1);
        cyc(); check_z("t4_next", 1, 8'h6B, 1, 0);
        drive_a(0, 8'h00, 0);

        // Lock persists while the locked source B goes idle
        drive_b(1, 8'h71, 0);
        drive_a(1, 8'h81, 1);
        #1;
        check("t5_b_ready", b_ready, 1);
        check("t5_a_ready", a_ready, 0);
        cyc(); check_z("t5_b0", 1, 8'h71, 0, 1);
        drive_b(0, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("t5_a_ready_locked", a_ready, 0);
            cyc();
        end
        drive_b(1, 8'h72, 1);
        #1;
        check("t5_b_ready_last", b_ready, 1);
        check("t5_a_ready_last", a_ready, 0);
        cyc(); check_z("t5_b1", 1, 8'h72, 1, 1);
        drive_b(0, 8'h00, 0);
        #1 check("t5_a_ready_after", a_ready, 1);
        cyc(); check_z("t5_a", 1, 8'h81, 1, 0);
        drive_a(0, 8'h00, 0);

        // Asynchronous reset mid-packet in LOCK_B with Z stalled
        drive_b(1, 8'h91, 0);
        #1 check("t6_b_ready", b_ready, 1);
        cyc(); check_z("t6_b0", 1, 8'h91, 0, 1);
        z_ready = 1'b0;
        drive_b(1, 8'h92, 0);
        #2 rst_n = 1'b0;
        #1;
        check_z("t6_rst", 0, 8'h00, 0, 0);
        check("t6_rst_a_ready", a_ready, 0);
        check("t6_rst_b_ready", b_ready, 0);
        drive_a(1, 8'hA5, 1);
        drive_b(1, 8'hB5, 1);
        z_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("t6_a_ready_first", a_ready, 1);
        check("t6_b_ready_first", b_ready, 0);
        cyc(); check_z("t6_a", 1, 8'hA5, 1, 0);
        drive_a(0, 8'h00, 0);
        drive_b(0, 8'h00, 0);
        cyc();

        // Randomized traffic; the model compare process does the checking
        a_rem = 0; b_rem = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (m_acc_a) begin a_valid = 1'b0; a_rem--; end
            if (m_acc_b) begin b_valid = 1'b0; b_rem--; end
            if (!a_valid) begin
                if ($urandom_range(3) != 0) begin
                    if (a_rem == 0) a_rem = $urandom_range(1, 4);
                    drive_a(1, 8'($urandom), a_rem == 1);
                end else begin
                    drive_a(0, 8'($urandom), 1'($urandom));
                end
            end
            if (!b_valid) begin
                if ($urandom_range(3) != 0) begin
                    if (b_rem == 0) b_rem = $urandom_range(1, 4);
                    drive_b(1, 8'($urandom), b_rem == 1);
                end else begin
                    drive_b(0, 8'($urandom), 1'($urandom));
                end
            end
            z_ready = ($urandom_range(3) != 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_arb2.md
# stream_arb2

Two-source stream arbiter with packet locking and a one-entry output register. It accepts beats from two valid/ready sources A and B and selects one with round-robin priority. Once a source wins, the grant holds until that source's LAST beat. Each selected beat goes through the internal 2:1 select and is registered onto a single output stream, together with the select value S that chose it. The block sits directly upstream of the downstream consumer and produces the select control that the plain 2:1 multiplexer stage otherwise needs from outside.

## Interface
- WIDTH, 8, data width of A_DATA, B_DATA, Z_DATA
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- A_VALID  in  1  source A beat present
- A_DATA  in  WIDTH  source A payload
- A_LAST  in  1  source A beat is final beat of packet
- A_READY  out  1  source A beat accepted this cycle when A_VALID=1
- B_VALID  in  1  source B beat present
- B_DATA  in  WIDTH  source B payload
- B_LAST  in  1  source B beat is final beat of packet
- B_READY  out  1  source B beat accepted this cycle when B_VALID=1
- Z_VALID  out  1  output beat present
- Z_DATA  out  WIDTH  output payload
- Z_LAST  out  1  output beat is final beat of packet
- S  out  1  source of the current output beat: 0 = A, 1 = B
- Z_READY  in  1  downstream accepts output beat

## Operation
- Transfer rules:
  - A transfer on any port occurs when VALID=1 and READY=1 at a rising CLK edge.
  - Sources must hold VALID, DATA and LAST stable until accepted.
  - Z follows the same rule: Z_VALID, Z_DATA, Z_LAST and S are held while Z_VALID=1 and Z_READY=0.
- Output register load: LOAD = !Z_VALID || Z_READY.
- Arbitration state machine:
  - IDLE: no packet in progress.
    - Only A_VALID=1: grant A. Only B_VALID=1: grant B.
    - Both valid: grant the source named by priority pointer PRI.
  - LOCK_A: only A can be granted; B_READY=0.
  - LOCK_B: only B can be granted; A_READY=0.
- Ready generation: A_READY = LOAD && grant==A; B_READY = LOAD && grant==B. At most one READY is high in any cycle.
- Accepted beat:
  - Z_DATA, Z_LAST and S are loaded from the granted source; Z_VALID is set to 1.
  - If there is no accepted beat and Z_READY=1 while Z_VALID=1, Z_VALID is cleared to 0.
- State transitions on an accepted beat:
  - IDLE, accepted A with A_LAST=0 -> LOCK_A. Accepted B with B_LAST=0 -> LOCK_B.
  - Accepted beat with LAST=1 in any state -> IDLE, and PRI is set to the other source.
  - Single-beat packets (LAST=1 accepted in IDLE) also flip PRI.
  - No accepted beat: state and PRI are unchanged. A locked source going idle does not release the lock.
- Priority pointer: PRI updates only at packet end, so round-robin fairness is per packet.
- Boundary conditions:
  - Both sources valid and Z stalled: no READY is asserted, state is unchanged, and no data is lost or duplicated.
  - Z_READY=1 with a new beat accepted in the same cycle: the old beat leaves and the new beat loads in that same edge, giving a throughput of one beat per cycle.
  - The VALID or LAST of the non-granted source has no effect.

## Timing
- Latency is one cycle: a beat accepted at edge N appears on Z_VALID/Z_DATA/Z_LAST/S after edge N.
- A_READY and B_READY are combinational from A_VALID, B_VALID, the state, PRI, Z_VALID and Z_READY. There is no combinational path from any DATA or LAST input to any output.
- Sustained throughput is 1 beat/cycle with Z_READY held at 1.
- Arbitration switch: the last beat of a packet from one source and the first beat of the other source are accepted on consecutive edges, with no bubble.
- Reset (RST_N=0, asynchronous, any time including mid-packet or while Z is stalled):
  - Z_VALID=0, Z_DATA=0, Z_LAST=0, S=0.
  - State returns to IDLE and PRI=A.
  - A_READY and B_READY are forced to 0 while RST_N=0.
  - Any in-flight packet is dropped.
- First rising edge after RST_N goes high: normal operation.

## Test plan
- Reset, then A only: A_DATA=0x11,0x22,0x33 with LAST on 0x33 and Z_READY=1. Required: Z carries 0x11,0x22,0x33 one cycle after each acceptance, S=0, Z_LAST=1 only on 0x33.
- Contention: both sources are valid with single-beat packets (A=0xA0.., B=0xB0..) and Z_READY=1. Required: the first grant goes to A, then grants alternate A,B,A,B on Z, one beat per cycle.
- Packet lock: A sends a 3-beat packet while B_VALID=1 throughout. Required: B_READY=0 until the edge that accepts A's LAST beat. B's first beat is accepted on the next edge with S=1, and there is no idle cycle between the two packets.
- Backpressure: Z_READY=0 for 4 cycles with Z holding 0x5A. Required: Z_VALID=1, Z_DATA=0x5A and S stay stable; A_READY=B_READY=0. On release, 0x5A transfers and the next beat loads on the same edge.
- Lock with idle source: B sends the first beat of a packet (LAST=0), then drops B_VALID for 3 cycles while A_VALID=1. Required: A_READY stays 0 and the lock persists until B's LAST beat is accepted.
- Mid-packet async reset: RST_N is pulled low between edges during LOCK_B while Z_VALID=1. Required: outputs clear immediately (Z_VALID=0, S=0). After release, with both sources valid, A is granted first.
